ctrl_store_sequencer: RTL and testbench

Sequences the 72-bit × 4096 control-store SRAM that drives the LUD datapath and shares its single port between the host (ZYNQ BRAM-style) loader and instruction playback. Playback supports free-run, single-step and a hardware breakpoint, and stops on the complete bit (bit 0) of a control word. The block sits between the SRAM macro and the control decoder, and replaces the ad-hoc start-gated muxing in the test wrapper.

---
 rtl/ctrl_store_sequencer_pkg.sv | 19 +
 rtl/ctrl_store_sequencer_if.sv | 25 ++
 rtl/ctrl_store_sequencer_port_arb.sv | 68 ++++++
 rtl/ctrl_store_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ctrl_store_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_store_sequencer_pkg.sv
// lctrl_pkg: shared constants and state encoding for the control-store
// sequencer.
//   DEF_ADDR_WIDTH / DEF_CTRL_WIDTH : default store geometry (4096 x 72)
//   COMPLETE_BIT                    : control-word bit that ends playback
//   state_e                         : sequencer FSM encoding
package lctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_CTRL_WIDTH = 72;
   localparam int COMPLETE_BIT   = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_DONE  = 3'd3
   } state_e;

endpackage

// File: rtl/ctrl_store_sequencer_if.sv
// Host loader port of the control-store sequencer (ZYNQ BRAM-style).
//   master : host side, drives host_req/host_we/host_addr/host_wdata
//   slave  : sequencer side, returns host_gnt/host_rvalid/host_rdata
interface ctrl_store_sequencer_if #(
   parameter int ADDR_WIDTH = lctrl_pkg::DEF_ADDR_WIDTH,
   parameter int CTRL_WIDTH = lctrl_pkg::DEF_CTRL_WIDTH
);
   logic                  host_req;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [CTRL_WIDTH-1:0] host_wdata;
   logic                  host_gnt;
   logic                  host_rvalid;
   logic [CTRL_WIDTH-1:0] host_rdata;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata
   );
endinterface

// File: rtl/ctrl_store_sequencer_port_arb.sv
// ctrl_port_arb: single-port SRAM mux between sequencer fetches and the host
// loader, plus the host read-return register.
//   CLK_100, RST          : clock, synchronous active-high reset
//   host                  : host port (slave modport)
//   host_allow            : sequencer state permits a host grant this cycle
//   seq_issue, seq_addr   : sequencer read request (always wins)
//   mem_csb/web/addr/din  : SRAM controls; addr/din hold when deselected
//   mem_dout              : SRAM read data, one-cycle latency
module ctrl_port_arb
   import lctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
   input  logic                  CLK_100,
   input  logic                  RST,
   ctrl_store_sequencer_if.slave host,
   input  logic                  host_allow,
   input  logic                  seq_issue,
   input  logic [ADDR_WIDTH-1:0] seq_addr,
   output logic                  mem_csb,
   output logic                  mem_web,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [CTRL_WIDTH-1:0] mem_din,
   input  logic [CTRL_WIDTH-1:0] mem_dout
);

   logic                  gnt;
   logic                  rvalid_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CTRL_WIDTH-1:0] din_q;
   logic [CTRL_WIDTH-1:0] rdata_q;

   assign gnt = host.host_req && host_allow && !seq_issue;

   always_comb begin
      mem_csb  = !(seq_issue || gnt);
      mem_web  = !(gnt && host.host_we);
      mem_addr = addr_q;
      mem_din  = din_q;
      if (seq_issue)
         mem_addr = seq_addr;
      else if (gnt)
         mem_addr = host.host_addr;
      if (gnt && host.host_we)
         mem_din = host.host_wdata;
   end

   always_ff @(posedge CLK_100) begin
      if (RST) begin
         addr_q   <= '0;
         din_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (!mem_csb) addr_q <= mem_addr;
         if (!mem_web) din_q  <= mem_din;
         rvalid_q <= gnt && !host.host_we;
         if (rvalid_q) rdata_q <= mem_dout;
      end
   end

   // Read data is live from the macro in the return cycle, then held.
   assign host.host_gnt    = gnt;
   assign host.host_rvalid = rvalid_q;
   assign host.host_rdata  = rvalid_q ? mem_dout : rdata_q;

endmodule

// File: rtl/ctrl_store_sequencer.sv
// ctrl_store_sequencer: shares the control-store SRAM between the host
// loader and instruction playback (free-run, single-step, breakpoint).
//   CLK_100, RST            : clock, synchronous active-high reset
//   host                    : host load/read port (slave modport)
//   start, step_mode, step  : playback control
//   brk_en, brk_addr, abort : breakpoint and abort
//   mem_*                   : SRAM macro port
//   ctrl_out, ctrl_valid    : delivered control word to the decoder
//   busy, done, wrap_err    : status
//   pc, word_count, state   : next fetch address, delivered count, debug
//
// state  | meaning
// IDLE   | no playback, host owns the port
// RUN    | fetch one word per cycle
// PAUSE  | halted by step_mode or breakpoint; step fetches one word
// DONE   | complete bit seen or store wrapped; pc/word_count held
module ctrl_store_sequencer
   import lctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
   input  logic                  CLK_100,
   input  logic                  RST,
   ctrl_store_sequencer_if.slave host,
   input  logic                  start,
   input  logic                  step_mode,
   input  logic                  step,
   input  logic                  brk_en,
   input  logic [ADDR_WIDTH-1:0] brk_addr,
   input  logic                  abort,
   output logic                  mem_csb,
   output logic                  mem_web,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [CTRL_WIDTH-1:0] mem_din,
   input  logic [CTRL_WIDTH-1:0] mem_dout,
   output logic [CTRL_WIDTH-1:0] ctrl_out,
   output logic                  ctrl_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  wrap_err,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic [2:0]            state
);

   localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;
   localparam logic [ADDR_WIDTH-1:0] PC_INC = 1;
   localparam logic [ADDR_WIDTH:0]   WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   WC_INC = 1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH:0]   wc_q;
   logic                  pend_q;   // sequencer read in flight, data now on mem_dout
   logic                  last_q;   // in-flight read was the top address
   logic                  skip_q;   // ignore breakpoint until the next issue
   logic                  wrap_q;

   logic launch, resume, brk_hit, seq_issue, advance, finish, host_allow;

   assign launch  = (state_q == ST_IDLE || state_q == ST_DONE) && start;
   assign resume  = (state_q == ST_PAUSE) && start && !step_mode;
   assign brk_hit = (state_q == ST_RUN) && brk_en && (pc_q == brk_addr)
                    && !skip_q && !last_q;
   // The top-address word ends playback whether or not it completes.
   assign finish  = pend_q && (mem_dout[COMPLETE_BIT] || last_q);
   // A fetch issued in the completion cycle still reaches the macro but is
   // never delivered and does not move pc.
   assign advance = seq_issue && !(pend_q && mem_dout[COMPLETE_BIT]);
   assign host_allow = !RST && (state_q != ST_RUN) && !launch;

   always_comb begin
      seq_issue = 1'b0;
      if (!RST && !abort && !last_q) begin
         case (state_q)
            ST_RUN:   seq_issue = !brk_hit;
            ST_PAUSE: seq_issue = step && !resume;
            default:  seq_issue = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = step_mode ? ST_PAUSE : ST_RUN;
         ST_RUN: begin
            if (brk_hit) state_d = ST_PAUSE;
            if (finish)  state_d = ST_DONE;
         end
         ST_PAUSE: begin
            if (resume) state_d = ST_RUN;
            if (finish) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_ff @(posedge CLK_100) begin
      if (RST) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         wc_q    <= '0;
         pend_q  <= 1'b0;
         last_q  <= 1'b0;
         skip_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pend_q && wc_q != WC_MAX) wc_q <= wc_q + WC_INC;
         if (abort) begin
            pend_q <= 1'b0;
            last_q <= 1'b0;
            skip_q <= 1'b0;
         end else if (launch) begin
            pc_q   <= '0;
            wc_q   <= '0;
            wrap_q <= 1'b0;
            pend_q <= 1'b0;
            last_q <= 1'b0;
            skip_q <= 1'b0;
         end else begin
            pend_q <= advance;
            if (pend_q) last_q <= 1'b0;
            if (advance) begin
               pc_q   <= pc_q + PC_INC;
               skip_q <= 1'b0;
               if (pc_q == PC_MAX) last_q <= 1'b1;
            end
            if (resume) skip_q <= 1'b1;
            if (pend_q && last_q && !mem_dout[COMPLETE_BIT]) wrap_q <= 1'b1;
         end
      end
   end

   ctrl_port_arb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH)
   ) u_arb (
      .CLK_100    (CLK_100),
      .RST        (RST),
      .host       (host),
      .host_allow (host_allow),
      .seq_issue  (seq_issue),
      .seq_addr   (pc_q),
      .mem_csb    (mem_csb),
      .mem_web    (mem_web),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   assign ctrl_valid = pend_q;
   assign ctrl_out   = pend_q ? mem_dout : '0;
   assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign done       = (state_q == ST_DONE);
   assign wrap_err   = wrap_q;
   assign pc         = pc_q;
   assign word_count = wc_q;
   assign state      = state_q;

endmodule

// File: tb/tb_ctrl_store_sequencer.sv
// Scoreboard bench for ctrl_store_sequencer with a behavioural SRAM model.
module tb_ctrl_store_sequencer;
   import lctrl_pkg::*;

   localparam int AW = 12;
   localparam int CW = 72;

   logic          CLK_100 = 1'b0;
   logic          RST     = 1'b1;
   logic          start, step_mode, step, brk_en, abort;
   logic [AW-1:0] brk_addr;
   logic          mem_csb, mem_web;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] mem_din, mem_dout;
   logic [CW-1:0] ctrl_out;
   logic          ctrl_valid, busy, done, wrap_err;
   logic [AW-1:0] pc;
   logic [AW:0]   word_count;
   logic [2:0]    state;

   logic [CW-1:0] sram [0:(1<<AW)-1];
   logic [CW-1:0] exp_q[$];
   logic [CW-1:0] rd_q[$];
   logic [CW-1:0] t3w [4];
   int checks = 0;
   int errors = 0;

   always #5 CLK_100 = ~CLK_100;

   ctrl_store_sequencer_if #(.ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) hif ();

   ctrl_store_sequencer #(.ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
      .CLK_100    (CLK_100),
      .RST        (RST),
      .host       (hif),
      .start      (start),
      .step_mode  (step_mode),
      .step       (step),
      .brk_en     (brk_en),
      .brk_addr   (brk_addr),
      .abort      (abort),
      .mem_csb    (mem_csb),
      .mem_web    (mem_web),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .ctrl_out   (ctrl_out),
      .ctrl_valid (ctrl_valid),
      .busy       (busy),
      .done       (done),
      .wrap_err   (wrap_err),
      .pc         (pc),
      .word_count (word_count),
      .state      (state)
   );

   always @(posedge CLK_100) begin
      if (!mem_csb) begin
         if (!mem_web) sram[mem_addr] <= mem_din;
         else          mem_dout       <= sram[mem_addr];
      end
   end

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_100);
      #1;
   endtask

   // Monitor: every delivered word and every host read return is scored.
   always @(negedge CLK_100) begin
      if (!RST) begin
         if (ctrl_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ctrl_unexpected actual=%0h required=none", ctrl_out);
            end else begin
               check("ctrl_word", ctrl_out, exp_q.pop_front());
            end
         end else begin
            check("ctrl_zero_when_invalid", ctrl_out, CW'(0));
         end
         if (hif.host_rvalid) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL host_rd_unexpected actual=%0h required=none", hif.host_rdata);
            end else begin
               check("host_rdata", hif.host_rdata, rd_q.pop_front());
            end
         end
      end
   end

   task automatic hw(input logic [AW-1:0] a, input logic [CW-1:0] d);
      hif.host_req   = 1'b1;
      hif.host_we    = 1'b1;
      hif.host_addr  = a;
      hif.host_wdata = d;
      #1;
      for (int i = 0; i < 16 && !hif.host_gnt; i++) tick();
      if (!hif.host_gnt) begin
         checks++;
         errors++;
         $display("FAIL host_wr_timeout actual=nogrant required=grant addr=%0h", a);
      end
      tick();
      hif.host_req = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      for (int i = 0; i < limit && !done; i++) tick();
      check(name, CW'(done), CW'(1));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"},   CW'(state),           CW'(0));
      check({tag, "_pc"},      CW'(pc),              CW'(0));
      check({tag, "_wc"},      CW'(word_count),      CW'(0));
      check({tag, "_flags"},   CW'({done, busy, wrap_err, ctrl_valid}), CW'(0));
      check({tag, "_host"},    CW'({hif.host_gnt, hif.host_rvalid}),   CW'(0));
      check({tag, "_ctrl"},    ctrl_out,             CW'(0));
      check({tag, "_rdata"},   hif.host_rdata,       CW'(0));
      check({tag, "_mem"},     CW'({mem_csb, mem_web}), CW'(3));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      start = 0; step_mode = 0; step = 0; brk_en = 0; brk_addr = '0; abort = 0;
      hif.host_req = 0; hif.host_we = 0; hif.host_addr = '0; hif.host_wdata = '0;
      mem_dout = '0;
      for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
      t3w[0] = CW'('h10); t3w[1] = CW'('h20); t3w[2] = CW'('h30); t3w[3] = CW'('h41);

      repeat (3) tick();
      check_reset("rst0");
      RST = 1'b0;
      tick();

      // Free-run over a 3-word program.
      hw(0, CW'('h10)); hw(1, CW'('h20)); hw(2, CW'('h31));
      exp_q.push_back(CW'('h10)); exp_q.push_back(CW'('h20)); exp_q.push_back(CW'('h31));
      pulse_start();
      check("t1_c1_valid", CW'(ctrl_valid), CW'(0));
      check("t1_c1_csb",   CW'(mem_csb),    CW'(0));
      check("t1_c1_addr",  CW'(mem_addr),   CW'(0));
      tick();
      check("t1_c2_valid", CW'(ctrl_valid), CW'(1));
      check("t1_c2_word",  ctrl_out,        CW'('h10));
      tick(); tick();
      check("t1_c4_done",  CW'(done),       CW'(0));
      tick();
      check("t1_c5_done",  CW'(done),       CW'(1));
      check("t1_wc",       CW'(word_count), CW'(3));
      check("t1_pc",       CW'(pc),         CW'(3));
      check("t1_state",    CW'(state),      CW'(3));
      check("t1_busy",     CW'(busy),       CW'(0));

      // Breakpoint at 1, single step, then resume.
      brk_en = 1'b1; brk_addr = 1;
      exp_q.push_back(CW'('h10));
      pulse_start();
      tick(); tick();
      check("t2_pause_state", CW'(state), CW'(2));
      check("t2_pause_pc",    CW'(pc),    CW'(1));
      check("t2_pause_busy",  CW'(busy),  CW'(1));
      exp_q.push_back(CW'('h20));
      step = 1'b1; tick(); step = 1'b0;
      check("t2_step_state", CW'(state), CW'(2));
      tick();
      check("t2_step_pc", CW'(pc),         CW'(2));
      check("t2_step_wc", CW'(word_count), CW'(2));
      exp_q.push_back(CW'('h31));
      pulse_start();
      wait_done(20, "t2_done");
      check("t2_wc", CW'(word_count), CW'(3));

      // Resume directly onto the breakpoint address: it must not re-trigger.
      exp_q.push_back(CW'('h10));
      pulse_start();
      tick(); tick();
      check("t2b_pause_pc", CW'(pc), CW'(1));
      exp_q.push_back(CW'('h20)); exp_q.push_back(CW'('h31));
      pulse_start();
      wait_done(20, "t2b_done");
      check("t2b_pc", CW'(pc), CW'(3));
      brk_en = 1'b0;

      // Single-step mode over four words.
      hw(2, CW'('h30)); hw(3, CW'('h41));
      step_mode = 1'b1;
      pulse_start();
      check("t3_pause", CW'(state), CW'(2));
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(t3w[i]);
         step = 1'b1; tick(); step = 1'b0;
         repeat (4) tick();
         check("t3_wc",   CW'(word_count), CW'(i + 1));
         check("t3_done", CW'(done),       CW'(i == 3));
      end
      step_mode = 1'b0;

      // Host locked out during RUN, served after done.
      hw(2, CW'('h31));
      exp_q.push_back(CW'('h10)); exp_q.push_back(CW'('h20)); exp_q.push_back(CW'('h31));
      hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 2;
      start = 1'b1;
      #1;
      check("t4_start_gnt", CW'(hif.host_gnt), CW'(0));
      tick();
      start = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         check("t4_run_gnt", CW'(hif.host_gnt), CW'(0));
         tick();
      end
      check("t4_done",     CW'(done),         CW'(1));
      check("t4_done_gnt", CW'(hif.host_gnt), CW'(1));
      rd_q.push_back(CW'('h31));
      tick();
      hif.host_req = 1'b0;
      check("t4_rvalid", CW'(hif.host_rvalid), CW'(1));
      check("t4_rdata",  hif.host_rdata,       CW'('h31));

      // Whole store without a complete bit wraps.
      for (int i = 0; i < (1 << AW); i++) hw(i[AW-1:0], CW'(2));
      for (int i = 0; i < (1 << AW); i++) exp_q.push_back(CW'(2));
      pulse_start();
      wait_done(5000, "t5_done");
      check("t5_wrap_err", CW'(wrap_err),     CW'(1));
      check("t5_wc",       CW'(word_count),   CW'(4096));
      check("t5_drained",  CW'(exp_q.size()), CW'(0));

      // Abort at the sixth word, then reset during a host write.
      for (int i = 0; i < 6; i++) exp_q.push_back(CW'(2));
      pulse_start();
      repeat (6) tick();
      check("t6_valid_w5", CW'(ctrl_valid), CW'(1));
      abort = 1'b1;
      #1;
      check("t6_abort_csb", CW'(mem_csb), CW'(1));
      tick();
      abort = 1'b0;
      check("t6_state", CW'(state),      CW'(0));
      check("t6_valid", CW'(ctrl_valid), CW'(0));
      check("t6_busy",  CW'(busy),       CW'(0));
      check("t6_wc",    CW'(word_count), CW'(6));
      repeat (2) tick();
      hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 5; hif.host_wdata = CW'('h77);
      RST = 1'b1;
      #1;
      check("t6_rst_gnt", CW'(hif.host_gnt), CW'(0));
      tick();
      RST = 1'b0;
      hif.host_req = 1'b0;
      #1;
      check_reset("t6_rst");
      check("t6_rst_no_write", sram[5], CW'(2));
      repeat (2) tick();

      check("queues_empty", CW'(exp_q.size() + rd_q.size()), CW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
